serial_add_ctrl: RTL and testbench
==================================

Name: serial_add_ctrl

Overview:
- Controller that shares one full-adder cell, built from two HalfAdd cells, across all bit positions of a WIDTH-bit addition.
- Processes one bit per clock, LSB first, under a Start/Busy/Done handshake.
- Sits between operand registers and the result consumer; trades latency for one adder cell instead of WIDTH cells.

Parameters:
- WIDTH, 8, operand/result width in bits (legal 2..32)

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- Start  input  1  request; sampled only in IDLE
- A  input  WIDTH  operand A, captured on the accepted Start edge
- B  input  WIDTH  operand B, captured on the accepted Start edge
- Busy  output  1  high while state is RUN
- Done  output  1  one-cycle pulse; Sum/Cout valid
- Sum  output  WIDTH  registered result, held until the next Done
- Cout  output  1  registered carry out of bit WIDTH-1, held with Sum

Behaviour:
- Reset:
  - Rst_n low immediately forces state=IDLE and clears Busy, Done, Sum, Cout, the bit index, the internal carry and the shift registers.
  - Reset mid-RUN aborts the addition and produces no Done.
- States: IDLE, RUN, DONE.
- IDLE:
  - With Start=1 at an edge: latch A and B into shift registers, set carry=0, index=0, go to RUN.
  - With Start=0: stay in IDLE.
- RUN: at each edge:
  - Compute bit = a0^b0^carry and carry' = a0&b0 | carry&(a0^b0) through the shared half-adder pair.
  - Shift the result register right, inserting bit at the MSB.
  - Shift the operand registers right, update carry and increment index.
  - At the edge where index = WIDTH-1, load Sum from the completed result and Cout from carry', then go to DONE.
- DONE:
  - Done=1 for exactly this one cycle.
  - Next edge goes to IDLE unconditionally.
  - Start in DONE is ignored.
- Latency:
  - Start sampled at edge 0; RUN covers edges 1..WIDTH.
  - Done high in the cycle after edge WIDTH; Sum/Cout change at edge WIDTH.
  - Minimum period between accepted Starts is WIDTH+2 cycles.
- Start while Busy or Done: ignored, with no queuing; A and B changes during RUN have no effect.
- Sum/Cout keep the previous result throughout RUN and change only together with Done.
- Arithmetic is unsigned modulo 2^WIDTH; Cout is the (WIDTH+1)th bit.
- Busy and Done are never high in the same cycle.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN
- Defined:
  - Adds output port Ovf (1 bit), reset 0.
  - Ovf is loaded at the same edge as Sum with carry-into-MSB XOR carry-out-of-MSB, i.e. two's-complement signed overflow.
  - Held with Sum.
- Undefined: no Ovf port and no extra logic; all other behaviour is identical.

Test Plan (WIDTH=8):
- Reset then idle: assert Rst_n=0 mid-cycle -> Busy=0, Done=0, Sum=0x00, Cout=0 immediately; hold 5 cycles with no Done.
- Basic add: A=0x35, B=0x4A, Start one cycle -> Busy high 8 cycles, Done pulse at cycle 9, Sum=0x7F, Cout=0.
- Full carry chain: A=0xFF, B=0x01 -> Sum=0x00, Cout=1. Then A=0xFF, B=0xFF -> Sum=0xFE, Cout=1. With SERIAL_ADD_OVF_EN, A=0x7F, B=0x01 -> Ovf=1.
- Ignored requests:
  - Hold Start=1 continuously with A=0x10, B=0x20 and change A to 0xAA at cycle 3 -> first Done gives Sum=0x30.
  - The next operation is accepted only in the cycle after Done (IDLE); exactly one Done per 10 cycles.
- Result hold: after Sum=0x30, start A=0x01, B=0x02 -> Sum stays 0x30 through all 8 RUN cycles and becomes 0x03 at the Done cycle.
- Reset mid-operation: Start A=0x0F, B=0x0F, drop Rst_n at RUN cycle 4 -> no Done, Sum=0x00; a new Start after release gives a correct Sum=0x1E.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit unsigned adder sharing one full-adder cell (two half adders).
// Latency: Start sampled at edge 0, result and Done after edge WIDTH; accepted Starts are WIDTH+2 cycles apart.
// Backpressure: none queued; Start is honoured only in IDLE, ignored while Busy or Done.
// Optional SERIAL_ADD_OVF_EN adds an Ovf output (two's-complement overflow, held with Sum).

module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             Ovf
`endif
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Shared full adder: first half adder sums the operand bits, second folds in the carry.
    logic ha0_s, ha0_c, bit_s, ha1_c, carry_nxt;

    half_add u_ha0 (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .s (ha0_s),
        .c (ha0_c)
    );

    half_add u_ha1 (
        .a (ha0_s),
        .b (carry_q),
        .s (bit_s),
        .c (ha1_c)
    );

    assign carry_nxt = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    res_d   = '0;
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = {bit_s, res_q[WIDTH-1:1]};
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                carry_d = carry_nxt;
                idx_d   = idx_q + IW'(1);
                if (idx_q == LAST_IDX) begin
                    sum_d   = {bit_s, res_q[WIDTH-1:1]};
                    cout_d  = carry_nxt;
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q is the carry into the MSB at this step
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign Busy = (state_q == S_RUN);
    assign Done = (state_q == S_DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed sums and cycle-exact handshake checks.
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         Clk;
    logic         Rst_n;
    logic         Start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Sum;
    logic         Cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         Ovf;
`endif

    int total = 0;
    int bad   = 0;
    logic [W-1:0] prev_sum;
    int done_cnt;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Start (Start),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .Done  (Done),
        .Sum   (Sum),
        .Cout  (Cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .Ovf   (Ovf)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // One full transaction from IDLE; returns one cycle after Done, back in IDLE.
    task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf);
        A = a;
        B = b;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int k = 0; k < W; k++) begin
            check("busy_run", {31'd0, Busy}, 32'd1);
            check("done_run", {31'd0, Done}, 32'd0);
            check("sum_hold", {24'd0, Sum}, {24'd0, prev_sum});
            if (k < W - 1) step();
        end
        step();
        check("done_pulse", {31'd0, Done}, 32'd1);
        check("busy_at_done", {31'd0, Busy}, 32'd0);
        check("sum", {24'd0, Sum}, {24'd0, exp_sum});
        check("cout", {31'd0, Cout}, {31'd0, exp_cout});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", {31'd0, Ovf}, {31'd0, exp_ovf});
`endif
        step();
        check("done_drop", {31'd0, Done}, 32'd0);
        check("sum_after", {24'd0, Sum}, {24'd0, exp_sum});
        prev_sum = exp_sum;
        if (exp_ovf === 1'bx) $display("note: ovf expectation unknown");
    endtask

    initial begin
        Rst_n = 1'b1;
        Start = 1'b0;
        A = '0;
        B = '0;
        prev_sum = '0;

        // Reset asserted mid-cycle takes effect without a clock edge
        #3 Rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_done", {31'd0, Done}, 32'd0);
        check("rst_sum", {24'd0, Sum}, 32'd0);
        check("rst_cout", {31'd0, Cout}, 32'd0);
        step();
        Rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("idle_done", {31'd0, Done}, 32'd0);
            check("idle_busy", {31'd0, Busy}, 32'd0);
        end

        run_add(8'h35, 8'h4A, 8'h7F, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        run_add(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
        run_add(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

        // Start held high: requests during RUN/DONE are dropped, A change during RUN ignored
        A = 8'h10;
        B = 8'h20;
        Start = 1'b1;
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (Done === 1'b1) done_cnt++;
            check("hold_done", {31'd0, Done}, {31'd0, (n == 8 || n == 18)});
            check("hold_busy", {31'd0, Busy}, {31'd0, (n <= 7 || (n >= 10 && n <= 17))});
            if (n == 8 || n == 18) begin
                check("hold_sum", {24'd0, Sum}, 32'h30);
                check("hold_cout", {31'd0, Cout}, 32'd0);
            end
            if (n == 2) A = 8'hAA;
            if (n == 9) A = 8'h10;
            if (n == 18) Start = 1'b0;
        end
        check("done_count", done_cnt, 32'd2);
        prev_sum = 8'h30;

        run_add(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

        // Reset during RUN cycle 4 aborts with no Done
        A = 8'h0F;
        B = 8'h0F;
        Start = 1'b1;
        step();
        Start = 1'b0;
        step();
        step();
        step();
        #2 Rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_sum", {24'd0, Sum}, 32'd0);
        check("abort_cout", {31'd0, Cout}, 32'd0);
        step();
        step();
        Rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("abort_nodone", {31'd0, Done}, 32'd0);
            check("abort_sum_hold", {24'd0, Sum}, 32'd0);
        end
        prev_sum = 8'h00;
        run_add(8'h0F, 8'h0F, 8'h1E, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
